// File: rtl/frame_event_sync.sv
// Multi-channel frame-aligned event synchroniser: latches asynchronous-to-frame events per channel
// and presents them at frame ticks, either as one-shot hold/cooldown pulses or as plain samples.
module frame_event_sync #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned HOLD_FRAMES     = 1,
  parameter int unsigned COOLDOWN_FRAMES = 0,
  parameter int unsigned CNT_W           = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_event,
  input  logic                    i_cal_frame,
  input  logic [N_CH-1:0]         i_mode,
  input  logic                    i_clear,
  output logic [N_CH-1:0]         o_event_frame,
  output logic [N_CH-1:0]         o_pending,
  output logic [N_CH-1:0]         o_busy,
  output logic [N_CH*CNT_W-1:0]   o_act_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [CD_W-1:0]   CD_INIT   =
      (COOLDOWN_FRAMES > 0) ? CD_W'(COOLDOWN_FRAMES - 1) : '0;

  typedef enum logic [1:0] {StIdle, StActive, StCooldown} state_e;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    state_e              r_state, w_state_d;
    logic [HOLD_W-1:0]   r_hold, w_hold_d;
    logic [CD_W-1:0]     r_cd, w_cd_d;
    logic                r_pend, w_pend_d;
    logic                r_out, w_out_d;
    logic                r_busy, w_busy_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                w_consume;

    always_comb begin
      w_state_d = r_state;
      w_hold_d  = r_hold;
      w_cd_d    = r_cd;
      w_out_d   = r_out;
      w_consume = 1'b0;
      if (i_cal_frame) begin
        if (i_mode[c]) begin
          // Frame-sample mode: FSM parked in idle, output mirrors the latched event.
          w_state_d = StIdle;
          w_out_d   = r_pend;
          w_consume = r_pend;
        end else begin
          unique case (r_state)
            StIdle: begin
              if (r_pend) begin
                w_state_d = StActive;
                w_hold_d  = HOLD_INIT;
                w_consume = 1'b1;
              end
            end
            StActive: begin
              if (r_hold != '0) begin
                w_hold_d = r_hold - HOLD_W'(1);
              end else if (COOLDOWN_FRAMES > 0) begin
                w_state_d = StCooldown;
                w_cd_d    = CD_INIT;
              end else if (r_pend) begin
                w_hold_d  = HOLD_INIT;
                w_consume = 1'b1;
              end else begin
                w_state_d = StIdle;
              end
            end
            StCooldown: begin
              if (r_cd != '0) begin
                w_cd_d = r_cd - CD_W'(1);
              end else if (r_pend) begin
                w_state_d = StActive;
                w_hold_d  = HOLD_INIT;
                w_consume = 1'b1;
              end else begin
                w_state_d = StIdle;
              end
            end
            default: w_state_d = StIdle;
          endcase
          w_out_d = (w_state_d == StActive);
        end
      end
      // A new event on the consuming tick survives into the next frame.
      w_pend_d = i_event[c] | (r_pend & ~w_consume);
      w_busy_d = (w_state_d != StIdle);
      w_cnt_d  = r_cnt;
      if (w_consume && (r_cnt != '1)) begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= StIdle;
        r_hold  <= '0;
        r_cd    <= '0;
        r_pend  <= 1'b0;
        r_out   <= 1'b0;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else if (i_clear) begin
        r_state <= StIdle;
        r_hold  <= '0;
        r_cd    <= '0;
        r_pend  <= 1'b0;
        r_out   <= 1'b0;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_d;
        r_hold  <= w_hold_d;
        r_cd    <= w_cd_d;
        r_pend  <= w_pend_d;
        r_out   <= w_out_d;
        r_busy  <= w_busy_d;
        r_cnt   <= w_cnt_d;
      end
    end

    assign o_event_frame[c]              = r_out;
    assign o_pending[c]                  = r_pend;
    assign o_busy[c]                     = r_busy;
    assign o_act_count[c*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_frame_event_sync.sv
// Scoreboard bench for frame_event_sync: two instances (hold 2 / cooldown 1, and hold 1 / no
// cooldown); expectations are queued by the stimulus and checked by an independent monitor.
module tb_frame_event_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [3:0]  ev0, mode0, ev1, mode1;
  logic        cal0, clr0, smp0, cal1, clr1, smp1;
  logic [3:0]  ef0, pd0, bz0, ef1, pd1, bz1;
  logic [15:0] ac0, ac1;

  frame_event_sync #(
    .N_CH(4), .HOLD_FRAMES(2), .COOLDOWN_FRAMES(1), .CNT_W(4)
  ) u_dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_event      (ev0),
    .i_cal_frame  (cal0),
    .i_mode       (mode0),
    .i_clear      (clr0),
    .o_event_frame(ef0),
    .o_pending    (pd0),
    .o_busy       (bz0),
    .o_act_count  (ac0)
  );

  frame_event_sync #(
    .N_CH(4), .HOLD_FRAMES(1), .COOLDOWN_FRAMES(0), .CNT_W(4)
  ) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_event      (ev1),
    .i_cal_frame  (cal1),
    .i_mode       (mode1),
    .i_clear      (clr1),
    .o_event_frame(ef1),
    .o_pending    (pd1),
    .o_busy       (bz1),
    .o_act_count  (ac1)
  );

  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  ev;
    logic [3:0]  busy;
    logic [3:0]  pend;
    logic [15:0] cnt;
  } exp_t;

  exp_t  q0[$], q1[$];
  string n0[$], n1[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic push(input int d, input logic [3:0] m, input logic [3:0] ev,
                      input logic [3:0] bz, input logic [3:0] pd, input logic [15:0] cn,
                      input string nm);
    exp_t e;
    e.mask = m; e.ev = ev; e.busy = bz; e.pend = pd; e.cnt = cn;
    if (d == 0) begin q0.push_back(e); n0.push_back(nm); end
    else        begin q1.push_back(e); n1.push_back(nm); end
  endtask

  task automatic check(input int d);
    exp_t        e;
    string       nm;
    logic [3:0]  aev, abz, apd;
    logic [15:0] acn, cm;
    if (d == 0) begin aev = ef0; abz = bz0; apd = pd0; acn = ac0; end
    else        begin aev = ef1; abz = bz1; apd = pd1; acn = ac1; end
    n_tests++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_sample dut%0d: ev=%b busy=%b pend=%b cnt=%h, required none",
               d, aev, abz, apd, acn);
      return;
    end
    if (d == 0) begin e = q0.pop_front(); nm = n0.pop_front(); end
    else        begin e = q1.pop_front(); nm = n1.pop_front(); end
    for (int i = 0; i < 4; i++) cm[i*4 +: 4] = {4{e.mask[i]}};
    if ((((aev ^ e.ev) & e.mask) != 4'h0) || (((abz ^ e.busy) & e.mask) != 4'h0) ||
        (((apd ^ e.pend) & e.mask) != 4'h0) || (((acn ^ e.cnt) & cm) != 16'h0)) begin
      n_fail++;
      $display("FAIL %s dut%0d: got ev=%b busy=%b pend=%b cnt=%h, required ev=%b busy=%b pend=%b cnt=%h (ch mask %b)",
               nm, d, aev, abz, apd, acn, e.ev, e.busy, e.pend, e.cnt, e.mask);
    end
  endtask

  // Monitor: samples on every frame tick / sample strobe, and right after reset assertion.
  initial begin
    bit rst_seen;
    bit t0, t1;
    rst_seen = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!rst_seen) begin
          rst_seen = 1'b1;
          #1;
          check(0);
        end
      end else begin
        rst_seen = 1'b0;
        t0 = cal0 | smp0;
        t1 = cal1 | smp1;
        if (t0 || t1) begin
          #2;
          if (t0) check(0);
          if (t1) check(1);
        end
      end
    end
  end

  task automatic drv0(input logic cal, input logic [3:0] ev, input logic smp, input logic clr);
    @(negedge clk);
    cal0 = cal; ev0 = ev; smp0 = smp; clr0 = clr;
  endtask

  task automatic drv1(input logic cal, input logic [3:0] ev, input logic smp);
    @(negedge clk);
    cal1 = cal; ev1 = ev; smp1 = smp;
  endtask

  initial begin
    int c;
    exp_t  e;
    string nm;
    ev0 = '0; mode0 = '0; cal0 = 1'b0; clr0 = 1'b0; smp0 = 1'b0;
    ev1 = '0; mode1 = '0; cal1 = 1'b0; clr1 = 1'b0; smp1 = 1'b0;

    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "reset_state");
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single event on ch0: hold two frames, one cooldown frame, then idle.
    drv0(1'b0, 4'b0001, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 16'h0000, "t1_pending");
    drv0(1'b0, 4'b0000, 1'b1, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, "t1_frame0");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, "t1_frame1");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0001, "t1_cooldown");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'h0001, "t1_idle");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'h0001, "t1_idle2");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);

    // ch1 event every frame: high,high,low cadence; count saturates at 15 after 15 activations.
    for (int k = 0; k < 51; k++) begin
      drv0(1'b0, 4'b0010, 1'b0, 1'b0);
      c = (k / 3 + 1 > 15) ? 15 : k / 3 + 1;
      push(0, 4'b0010, ((k % 3) != 2) ? 4'b0010 : 4'b0000, 4'b0010,
           ((k % 3) != 0) ? 4'b0010 : 4'b0000, 16'(c) << 4, $sformatf("t2_frame%0d", k));
      drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    end
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);

    // Async reset in the middle of a ch0 hold.
    drv0(1'b0, 4'b0001, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0002, "t5_active");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "t5_reset_mid_hold");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "t5_post_reset");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "t5_post_reset_b2b");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);

    // Clear coincident with a tick and an event.
    drv0(1'b0, 4'b0001, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, "t5_pre_clear");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0100, 1'b0, 1'b0);
    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "t5_clear_on_tick");
    drv0(1'b1, 4'b0001, 1'b0, 1'b1);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, "t5_post_clear");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);

    // Mode 1 on all channels: event on ch2 exactly at a tick is carried.
    mode0 = 4'hF;
    push(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 16'h0000, "t3_carry");
    drv0(1'b1, 4'b0100, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 16'h0100, "t3_present");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    push(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 16'h0100, "t3_after");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);

    // ch0 switched to mode 1 mid-hold: next tick samples pending, busy drops.
    mode0 = 4'h0;
    drv0(1'b0, 4'b0001, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, "t6_active");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);
    mode0[0] = 1'b1;
    push(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0001, "t6_hold_before_tick");
    drv0(1'b0, 4'b0000, 1'b1, 1'b0);
    push(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'h0001, "t6_sampled");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0001, 1'b0, 1'b0);
    push(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h0002, "t6_sampled_event");
    drv0(1'b1, 4'b0000, 1'b0, 1'b0);
    drv0(1'b0, 4'b0000, 1'b0, 1'b0);

    // Hold 1, no cooldown: ch3 event every frame keeps output high with no gap.
    for (int k = 0; k < 6; k++) begin
      drv1(1'b0, 4'b1000, 1'b0);
      push(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 16'(k + 1) << 12, $sformatf("t4_tick%0d", k));
      drv1(1'b1, 4'b0000, 1'b0);
      push(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 16'(k + 1) << 12, $sformatf("t4_mid%0d", k));
      drv1(1'b0, 4'b0000, 1'b1);
    end
    push(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 16'h6000, "t4_idle");
    drv1(1'b1, 4'b0000, 1'b0);
    drv1(1'b0, 4'b0000, 1'b0);

    repeat (4) @(negedge clk);
    while (q0.size() > 0) begin
      e = q0.pop_front(); nm = n0.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s dut0: got no sample, required ev=%b busy=%b pend=%b cnt=%h",
               nm, e.ev, e.busy, e.pend, e.cnt);
    end
    while (q1.size() > 0) begin
      e = q1.pop_front(); nm = n1.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s dut1: got no sample, required ev=%b busy=%b pend=%b cnt=%h",
               nm, e.ev, e.busy, e.pend, e.cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
